// File: rtl/eth_10g_st_adapter_pkg.sv
// Shared widths and helpers for the 10G MAC Avalon-ST timing adapter.
package eth_10g_st_adapter_pkg;

  localparam int DROP_CNT_W = 16;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // The count holds at all-ones rather than wrapping to zero.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] value);
    return (value == {DROP_CNT_W{1'b1}}) ? value : value + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/eth_10g_st_sc_fifo.sv
// Single-clock first-word-fall-through FIFO: storage, pointers and fill level.
module eth_10g_st_sc_fifo
  import eth_10g_st_adapter_pkg::*;
#(
  parameter int W     = 47,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_wdata,
  output logic [W-1:0]               o_rdata,
  output logic [cnt_width(DEPTH)-1:0] o_fill_level
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_fill;

  // Storage is cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_fill <= r_fill + CNT_W'(1);
        2'b01:   r_fill <= r_fill - CNT_W'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

  assign o_rdata      = r_mem[r_rd_ptr];
  assign o_fill_level = r_fill;

endmodule

// File: rtl/eth_10g_st_timing_adapter_fifo.sv
// Avalon-ST timing adapter: absorbs downstream backpressure for a source with
// no ready input, dropping and counting beats that arrive while full.
module eth_10g_st_timing_adapter_fifo
  import eth_10g_st_adapter_pkg::*;
#(
  parameter int DATA_W       = 40,
  parameter int ERR_W        = 7,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = 6
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [ERR_W-1:0]            in_error,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic [ERR_W-1:0]            out_error,
  input  logic                        out_ready,
  output logic [cnt_width(DEPTH)-1:0] fill_level,
  output logic                        almost_full,
  output logic                        overflow,
  output logic                        overflow_sticky,
  output logic [DROP_CNT_W-1:0]       drop_count,
  input  logic                        clear_stats
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam int ENT_W = DATA_W + ERR_W;

  // Handshake: upstream in_valid is never refused (no ready); downstream
  // transfers a beat on any cycle where out_valid & out_ready (ready latency 0).
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_full;
  logic [CNT_W-1:0] w_fill;
  logic [ENT_W-1:0] w_rdata;

  logic                  r_overflow;
  logic                  r_sticky;
  logic [DROP_CNT_W-1:0] r_drop_count;

  assign w_full = (w_fill == CNT_W'(DEPTH));
  assign w_pop  = out_valid & out_ready;
  assign w_push = in_valid & (!w_full | w_pop);
  assign w_drop = in_valid & w_full & !w_pop;

  eth_10g_st_sc_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_wdata      ({in_error, in_data}),
    .o_rdata      (w_rdata),
    .o_fill_level (w_fill)
  );

  // A clear in the same cycle as a drop wipes old history, then counts the drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow   <= 1'b0;
      r_sticky     <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_overflow <= w_drop;
      if (clear_stats) begin
        r_sticky     <= w_drop;
        r_drop_count <= w_drop ? DROP_CNT_W'(1) : '0;
      end else begin
        r_sticky <= r_sticky | w_drop;
        if (w_drop) r_drop_count <= sat_inc(r_drop_count);
      end
    end
  end

  assign out_valid       = (w_fill != '0);
  assign out_data        = w_rdata[DATA_W-1:0];
  assign out_error       = w_rdata[ENT_W-1:DATA_W];
  assign fill_level      = w_fill;
  assign almost_full     = (w_fill >= CNT_W'(AFULL_THRESH));
  assign overflow        = r_overflow;
  assign overflow_sticky = r_sticky;
  assign drop_count      = r_drop_count;

endmodule

// File: tb/tb_eth_10g_st_timing_adapter_fifo.sv
// Directed bench for the 10G Avalon-ST timing adapter FIFO (DEPTH=8, THRESH=6).
module tb_eth_10g_st_timing_adapter_fifo;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [39:0] in_data;
  logic [6:0]  in_error;
  logic        out_valid;
  logic [39:0] out_data;
  logic [6:0]  out_error;
  logic        out_ready;
  logic [3:0]  fill_level;
  logic        almost_full;
  logic        overflow;
  logic        overflow_sticky;
  logic [15:0] drop_count;
  logic        clear_stats;

  int checks   = 0;
  int failures = 0;

  logic [46:0] exp_q[$];
  logic [15:0] exp_cnt;
  logic        exp_sticky;

  eth_10g_st_timing_adapter_fifo #(
    .DATA_W(40), .ERR_W(7), .DEPTH(8), .AFULL_THRESH(6)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_error        (in_error),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_error       (out_error),
    .out_ready       (out_ready),
    .fill_level      (fill_level),
    .almost_full     (almost_full),
    .overflow        (overflow),
    .overflow_sticky (overflow_sticky),
    .drop_count      (drop_count),
    .clear_stats     (clear_stats)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_cnt    = 16'd0;
    exp_sticky = 1'b0;
  endtask

  // One clock with the given inputs; head checked before the edge,
  // registered state and statistics checked 1 time unit after it.
  task automatic cycle(input logic v, input logic [39:0] d, input logic rdy, input logic clr);
    logic m_pop, m_drop, m_push;
    in_valid    = v;
    in_data     = d;
    in_error    = d[6:0];
    out_ready   = rdy;
    clear_stats = clr;
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("out_data", out_data, exp_q[0][39:0]);
      check("out_error", out_error, exp_q[0][46:40]);
    end
    m_pop  = (exp_q.size() != 0) && rdy;
    m_drop = v && (exp_q.size() == 8) && !m_pop;
    m_push = v && !m_drop;
    @(posedge clk);
    #1;
    if (m_pop)  void'(exp_q.pop_front());
    if (m_push) exp_q.push_back({d[6:0], d});
    if (clr) exp_cnt = m_drop ? 16'd1 : 16'd0;
    else if (m_drop && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    exp_sticky = clr ? m_drop : (exp_sticky | m_drop);
    check("overflow", overflow, m_drop);
    check("sticky", overflow_sticky, exp_sticky);
    check("drop_count", drop_count, exp_cnt);
    check("fill_level", fill_level, exp_q.size());
    check("almost_full", almost_full, exp_q.size() >= 6);
    in_valid    = 1'b0;
    clear_stats = 1'b0;
  endtask

  initial begin
    logic        stalled;
    logic [39:0] held;
    logic        rdy;
    int          sent;

    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_error = '0;
    out_ready = 1'b0; clear_stats = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_fill", fill_level, 0);
    check("rst_out_data", out_data, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_sticky", overflow_sticky, 0);
    check("rst_almost_full", almost_full, 0);

    // 20 beats streaming with ready high: 1-cycle latency, fill never above 1
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 40'(i), 1'b1, 1'b0);
      check("stream_fill_le1", fill_level <= 1, 1);
      if (i > 0) check("stream_data", out_data, 40'(i));
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("stream_drops", drop_count, 0);
    check("stream_empty", out_valid, 0);

    // fill to 8 with ready low; almost_full from the 6th beat
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 40'(i), 1'b0, 1'b0);
      check("fill_af", almost_full, (i >= 5));
    end
    check("full_level", fill_level, 8);
    cycle(1'b1, 40'd8, 1'b0, 1'b0);
    check("drop9_pulse", overflow, 1);
    cycle(1'b1, 40'd9, 1'b0, 1'b0);
    check("drop10_pulse", overflow, 1);
    check("drop_count_2", drop_count, 2);
    check("sticky_set", overflow_sticky, 1);
    for (int i = 0; i < 8; i++) begin
      check("drain_order", out_data, 40'(i));
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    check("drained", out_valid, 0);
    check("drain_no_pulse", overflow, 0);

    // full with simultaneous push and pop: no drop, level stays 8
    for (int i = 0; i < 8; i++) cycle(1'b1, 40'(100 + i), 1'b0, 1'b0);
    cycle(1'b1, 40'd200, 1'b1, 1'b0);
    check("pp_no_drop", overflow, 0);
    check("pp_fill", fill_level, 8);
    check("pp_count", drop_count, 2);
    for (int i = 0; i < 8; i++) begin
      check("pp_order", out_data, (i == 7) ? 40'd200 : 40'(101 + i));
      cycle(1'b0, '0, 1'b1, 1'b0);
    end

    // saturation: fill then hold in_valid for 70000 dropped beats
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("clear_count", drop_count, 0);
    check("clear_sticky", overflow_sticky, 0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 40'(300 + i), 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) cycle(1'b1, 40'hAB, 1'b0, 1'b0);
    check("saturated", drop_count, 16'hFFFF);
    cycle(1'b1, 40'hCD, 1'b0, 1'b1);
    check("clr_drop_count", drop_count, 1);
    check("clr_drop_sticky", overflow_sticky, 1);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // asynchronous reset mid-transfer with 5 entries held
    for (int i = 0; i < 5; i++) cycle(1'b1, 40'(400 + i), 1'b0, 1'b0);
    check("pre_rst_fill", fill_level, 5);
    in_valid = 1'b1; in_data = 40'd999; out_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_fill", fill_level, 0);
    check("arst_count", drop_count, 0);
    check("arst_sticky", overflow_sticky, 0);
    check("arst_out_data", out_data, 0);
    check("arst_af", almost_full, 0);
    in_valid = 1'b0;
    model_reset();
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    cycle(1'b1, 40'd555, 1'b0, 1'b0);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_data", out_data, 40'd555);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // random ready, 1000 beats, error = data[6:0], stable while stalled
    sent = 0;
    while (sent < 1000) begin
      logic v;
      v   = ($urandom_range(0, 3) != 0);
      rdy = $urandom_range(0, 1);
      stalled = out_valid && !rdy;
      held    = out_data;
      cycle(v, 40'(sent * 7 + 3), rdy, 1'b0);
      if (stalled) check("stall_stable", out_data, held);
      if (v) sent++;
    end
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("final_empty", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_10g_st_timing_adapter_fifo.md
# eth_10g_st_timing_adapter_fifo

Parametrised Avalon-ST timing adapter for the 10G MAC TX status/splitter paths. It absorbs downstream backpressure in a single-clock FIFO, because the upstream source cannot be backpressured and has no ready input. Beats that arrive when the FIFO is full are dropped. Each drop is flagged, made sticky and counted, so status loss is visible in hardware rather than only in simulation.

## Interface
Parameters:
- DATA_W, 40, data payload width.
- ERR_W, 7, error sideband width.
- DEPTH, 8, FIFO entries; power of two, ≥2.
- AFULL_THRESH, 6, almost_full asserts when fill_level ≥ this value; range 1..DEPTH.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream beat valid; no ready is returned.
- in_data  in  DATA_W  upstream data.
- in_error  in  ERR_W  upstream error bits.
- out_valid  out  1  head entry present.
- out_data  out  DATA_W  head data.
- out_error  out  ERR_W  head error.
- out_ready  in  1  downstream ready, ready latency 0.
- fill_level  out  $clog2(DEPTH)+1  entries held.
- almost_full  out  1  fill_level ≥ AFULL_THRESH.
- overflow  out  1  one-cycle pulse per dropped beat.
- overflow_sticky  out  1  set by any drop; cleared only by clear_stats or reset.
- drop_count  out  16  saturating dropped-beat count.
- clear_stats  in  1  synchronous clear of overflow_sticky and drop_count.

## Operation
- pop = out_valid & out_ready.
- push = in_valid & (fill_level != DEPTH | pop).
- drop = in_valid & fill_level == DEPTH & !pop.
- The FIFO is first-word-fall-through:
  - out_data and out_error come from storage[rd_ptr].
  - out_valid = (fill_level != 0).
- Pointers are $clog2(DEPTH) bits and wrap naturally. fill_level changes by +push −pop.
- A beat and its error bits are stored together and never split.
- Full with push and pop in the same cycle: the beat is accepted and fill_level stays at DEPTH.
- Empty with in_valid: the beat is written and is not bypassed. out_valid rises the next cycle.
- Drop behaviour:
  - overflow is registered, high in the cycle after the drop.
  - overflow_sticky sets in the same registered update.
  - drop_count increments and saturates at 0xFFFF.
- clear_stats in the same cycle as a drop: the clear applies first, then the drop is counted. Result next cycle: drop_count = 1, overflow_sticky = 1.
- overflow pulses are not affected by clear_stats.
- Reset, at any time including mid-burst:
  - pointers, fill_level, out_valid, overflow, overflow_sticky, drop_count and almost_full all go to 0.
  - Stored contents are discarded. out_data and out_error read 0 after reset; storage is reset to 0.

## Timing
- Latency from in_valid to out_valid is 1 cycle when the FIFO is empty.
- out_data and out_error are held stable while out_valid & !out_ready.
- almost_full, out_valid and fill_level are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output except through the registered state.
- The upstream has no combinational dependency on out_ready.
- Sustained throughput is 1 beat per cycle when out_ready is held high.

## Structure
- Package eth_10g_st_adapter_pkg holds:
  - DROP_CNT_W = 16
  - the saturating-increment function
  - the localparam helpers for the pointer and count widths
- Sub-module eth_10g_st_sc_fifo contains the storage, pointers, fill_level and push/pop logic.
- The top level adds drop detection, the statistics logic and almost_full.

## Test plan
- Stream 20 beats with out_ready = 1 and data = index → output matches with 1-cycle latency; drop_count = 0; fill_level ≤ 1.
- DEPTH = 8, out_ready = 0, 8 beats → fill_level = 8 and almost_full = 1 from the 6th beat. A 9th and 10th beat → two overflow pulses, drop_count = 2, sticky = 1. Releasing ready → exactly beats 0..7 emerge in order.
- Full FIFO with in_valid = 1 and out_ready = 1 in the same cycle → no drop; fill_level stays at 8; the new beat emerges after the 7 older entries.
- 70000 drops → drop_count = 0xFFFF. clear_stats together with a drop → drop_count = 1, sticky = 1.
- reset_n asserted asynchronously mid-transfer with 5 entries held → out_valid = 0 immediately and all counters are 0. The next beat after release emerges 1 cycle later.
- out_ready toggled randomly 1000 beats with error bits = data[6:0] → no reordering, error stays paired with its data, and out_data is stable while stalled.
